pixel_window_capture: RTL and testbench
=======================================

// Module: pixel_window_capture
// PURPOSE
//  Synthesisable frame-grab block for the Sprites VGA pipeline. Samples the pixel stream
//  (row, column, pixel) inside a run-time rectangular window and packs pixels MSB-first into
//  words. Words drain through a FIFO with a valid/ready handshake. Supports one-shot and
//  continuous capture, zero-padded end-of-window flush and sticky overflow reporting.
// PARAMETERS
//  POS_W       10  width of row/column coordinates and window fields
//  PIXEL_BITS  2   bits per pixel; must divide WORD_BITS
//  WORD_BITS   32  packed output word width
//  FIFO_DEPTH  8   output FIFO entries (power of 2, >=2)
// PORTS
//  i_Clk          in   1           system clock, all logic on rising edge
//  i_Rst_L        in   1           synchronous reset, active-low
//  i_Arm          in   1           1-cycle pulse: latch window/mode, start capture
//  i_Continuous   in   1           0 = one-shot, 1 = re-arm every frame (latched at arm)
//  i_Win_X0       in   POS_W       window first column
//  i_Win_Y0       in   POS_W       window first row
//  i_Win_W        in   POS_W       window width in pixels, >=1
//  i_Win_H        in   POS_W       window height in rows, >=1
//  i_Pix_Valid    in   1           row/column/pixel valid this cycle
//  i_Row          in   POS_W       current raster row
//  i_Column       in   POS_W       current raster column
//  i_Pixel        in   PIXEL_BITS  current pixel value
//  o_Word         out  WORD_BITS   FIFO head word
//  o_Word_Valid   out  1           FIFO not empty
//  i_Word_Ready   in   1           consumer accepts o_Word when valid && ready
//  o_Busy         out  1           state != IDLE
//  o_Frame_Done   out  1           1-cycle pulse after last window word is pushed or dropped
//  o_Overflow     out  1           sticky: a word was dropped because the FIFO was full
//  o_Word_Count   out  16          words pushed this frame; saturates at 16'hFFFF
// BEHAVIOUR
//  - Reset (i_Rst_L=0 at an edge): state IDLE, FIFO empty, shift reg and counters 0, all
//    outputs 0. Reset mid-capture discards the partial word and all queued words.
//  - FSM: IDLE -arm-> WAIT_SOF -(valid && row==0 && col==0)-> CAPTURE -last pixel->
//    FLUSH (1 cycle) -> IDLE (one-shot) or WAIT_SOF (continuous).
//  - i_Arm outside IDLE is ignored. i_Arm sampled in IDLE also clears o_Overflow and
//    o_Word_Count, and latches the window and mode.
//  - In-window: valid && Y0<=row<Y0+H && X0<=col<X0+W. Compare in POS_W+1 bits; no wrap.
//    The SOF pixel (0,0) is captured in the same cycle if it lies in the window.
//  - Packing: sr <= {sr[WORD_BITS-PIXEL_BITS-1:0], pixel}, so the first pixel lands in the MSBs.
//    A word completes at the (WORD_BITS/PIXEL_BITS)th pixel and is pushed on that edge.
//  - Last pixel (row==Y0+H-1, col==X0+W-1): if the word is partial, it is left-shifted with
//    zero fill to full width and pushed in FLUSH. o_Frame_Done pulses in FLUSH.
//  - FIFO: push while full -> word dropped, o_Overflow<=1, count not incremented.
//    Push and pop in the same cycle while full is allowed (no drop). Empty FIFO to
//    o_Word_Valid latency is 1 cycle after push. o_Word is stable while valid && !ready.
//  - o_Word_Valid and FIFO contents persist in IDLE until drained.
// STRUCTURE
//  - Shared package pwc_pkg: state encoding localparams (IDLE, WAIT_SOF, CAPTURE, FLUSH),
//    PIXELS_PER_WORD = WORD_BITS/PIXEL_BITS.
//  - Sub-module sync_fifo (WIDTH, DEPTH): registered-output synchronous FIFO with full/empty.
//  - Top level: window compare, packer shift reg plus pixel counter, FSM, statistics.
// TESTING
//  1 Reset: hold i_Rst_L=0 for 3 cycles mid-CAPTURE -> o_Busy=0, o_Word_Valid=0,
//    o_Overflow=0, o_Word_Count=0.
//  2 Window X0=16,Y0=0,W=256,H=2, pixel=col[1:0], ready=1 -> 32 words, first 32'h1B1B1B1B;
//    o_Frame_Done pulses once; o_Word_Count=32.
//  3 Partial flush W=5,H=1,X0=0, pixels 3,3,3,3,3 -> single word 32'hFFC00000.
//  4 Backpressure: ready=0, window emits 10 words, DEPTH=8 -> 8 words retained,
//    o_Overflow=1, o_Word_Count=8; after ready=1, exactly 8 words drain in order.
//  5 Continuous mode, 3 frames W=16,H=1 -> 3 Frame_Done pulses, o_Busy stays 1;
//    i_Arm mid-frame has no effect.
//  6 Window at bounds X0=1020,W=8 (POS_W=10, raster wraps to col 0) -> only cols
//    1020..1023 captured; flush word holds 4 pixels then zero fill.

Source files
------------

// File: rtl/pwc_pkg.sv
// pwc_pkg: shared FSM encoding and packing defaults for pixel_window_capture
package pwc_pkg;
    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] WAIT_SOF = 2'd1;
    localparam logic [1:0] CAPTURE  = 2'd2;
    localparam logic [1:0] FLUSH    = 2'd3;
    localparam int PWC_POS_W       = 10;
    localparam int PWC_PIXEL_BITS  = 2;
    localparam int PWC_WORD_BITS   = 32;
    localparam int PWC_FIFO_DEPTH  = 8;
    localparam int PIXELS_PER_WORD = PWC_WORD_BITS / PWC_PIXEL_BITS;
endpackage

// File: rtl/pixel_window_capture_if.sv
// pixel_window_capture_if: valid/ready stream of packed capture words
interface pixel_window_capture_if #(parameter int WORD_BITS = 32);
    logic [WORD_BITS-1:0] word;
    logic                 word_valid;
    logic                 word_ready;
    modport master (output word, word_valid, input word_ready);
    modport slave  (input word, word_valid, output word_ready);
endinterface

// File: rtl/sync_fifo.sv
// sync_fifo: synchronous FIFO over a register array with occupancy-based full/empty
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic             i_Clk,
    input  logic             i_Rst_L,
    input  logic             i_Push,
    input  logic [WIDTH-1:0] i_Data,
    input  logic             i_Pop,
    output logic [WIDTH-1:0] o_Data,
    output logic             o_Full,
    output logic             o_Empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] CNT_FULL = DEPTH[AW:0];
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr, r_rd;
    logic [AW:0]      r_cnt;
    logic             w_push, w_pop;
    assign o_Empty = r_cnt == '0;
    assign o_Full  = r_cnt == CNT_FULL;
    assign w_pop   = i_Pop && !o_Empty;
    assign w_push  = i_Push && (!o_Full || w_pop);
    assign o_Data  = o_Empty ? '0 : r_mem[r_rd];
    always_ff @(posedge i_Clk)
        if (w_push) r_mem[r_wr] <= i_Data;
    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            r_wr  <= w_push ? r_wr + 1'b1 : r_wr;
            r_rd  <= w_pop ? r_rd + 1'b1 : r_rd;
            r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end
endmodule

// File: rtl/pixel_window_capture.sv
// pixel_window_capture: grabs pixels inside a rectangular window, packs them MSB-first into FIFO words
module pixel_window_capture
    import pwc_pkg::*;
#(
    parameter int POS_W      = PWC_POS_W,
    parameter int PIXEL_BITS = PWC_PIXEL_BITS,
    parameter int WORD_BITS  = PWC_WORD_BITS,
    parameter int FIFO_DEPTH = PWC_FIFO_DEPTH
) (
    input  logic                  i_Clk,
    input  logic                  i_Rst_L,
    input  logic                  i_Arm,
    input  logic                  i_Continuous,
    input  logic [POS_W-1:0]      i_Win_X0,
    input  logic [POS_W-1:0]      i_Win_Y0,
    input  logic [POS_W-1:0]      i_Win_W,
    input  logic [POS_W-1:0]      i_Win_H,
    input  logic                  i_Pix_Valid,
    input  logic [POS_W-1:0]      i_Row,
    input  logic [POS_W-1:0]      i_Column,
    input  logic [PIXEL_BITS-1:0] i_Pixel,
    pixel_window_capture_if.master o_Words,
    output logic                  o_Busy,
    output logic                  o_Frame_Done,
    output logic                  o_Overflow,
    output logic [15:0]           o_Word_Count
);
    localparam int PPW = WORD_BITS / PIXEL_BITS;
    localparam int CW  = $clog2(PPW + 1);
    logic [1:0]           r_state, w_next;
    logic                 r_cont;
    logic [POS_W-1:0]     r_x0, r_y0, r_x_last, r_y_last;
    logic [WORD_BITS-1:0] r_sr, w_sr_next, w_push_data;
    logic [CW-1:0]        r_cnt;
    logic [POS_W:0]       w_x_lim, w_y_lim;
    logic                 w_sof, w_in_win, w_take, w_last, w_word_done, w_flush;
    logic                 w_push, w_pop, w_full, w_empty, w_accept, w_drop, w_arm;
    // window end is clipped to the raster edge so windows hanging off the right/bottom still finish
    assign w_x_lim     = {1'b0, i_Win_X0} + {1'b0, i_Win_W};
    assign w_y_lim     = {1'b0, i_Win_Y0} + {1'b0, i_Win_H};
    assign w_arm       = r_state == IDLE && i_Arm;
    assign w_sof       = i_Pix_Valid && i_Row == '0 && i_Column == '0;
    assign w_in_win    = i_Row >= r_y0 && i_Row <= r_y_last && i_Column >= r_x0 && i_Column <= r_x_last;
    assign w_take      = i_Pix_Valid && w_in_win && (r_state == CAPTURE || (r_state == WAIT_SOF && w_sof));
    assign w_last      = w_take && i_Row == r_y_last && i_Column == r_x_last;
    assign w_sr_next   = {r_sr[WORD_BITS-PIXEL_BITS-1:0], i_Pixel};
    assign w_word_done = w_take && r_cnt == CW'(PPW - 1);
    assign w_flush     = r_state == FLUSH && r_cnt != '0;
    assign w_push      = w_word_done || w_flush;
    assign w_push_data = w_flush ? r_sr << ((PPW - int'(r_cnt)) * PIXEL_BITS) : w_sr_next;
    assign w_pop       = o_Words.word_valid && o_Words.word_ready;
    assign w_accept    = w_push && (!w_full || w_pop);
    assign w_drop      = w_push && w_full && !w_pop;
    assign w_next      = r_state == IDLE     ? (i_Arm ? WAIT_SOF : IDLE)
                       : r_state == WAIT_SOF ? (w_last ? FLUSH : w_sof ? CAPTURE : WAIT_SOF)
                       : r_state == CAPTURE  ? (w_last ? FLUSH : CAPTURE)
                       : (r_cont ? WAIT_SOF : IDLE);
    assign o_Busy       = r_state != IDLE;
    assign o_Frame_Done = r_state == FLUSH;
    assign o_Words.word_valid = !w_empty;
    sync_fifo #(.WIDTH(WORD_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
        .i_Clk   (i_Clk),
        .i_Rst_L (i_Rst_L),
        .i_Push  (w_push),
        .i_Data  (w_push_data),
        .i_Pop   (o_Words.word_ready),
        .o_Data  (o_Words.word),
        .o_Full  (w_full),
        .o_Empty (w_empty)
    );
    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            r_state      <= IDLE;
            r_cont       <= 1'b0;
            r_x0         <= '0;
            r_y0         <= '0;
            r_x_last     <= '0;
            r_y_last     <= '0;
            r_sr         <= '0;
            r_cnt        <= '0;
            o_Overflow   <= 1'b0;
            o_Word_Count <= '0;
        end else begin
            r_state <= w_next;
            if (w_arm) begin
                r_cont       <= i_Continuous;
                r_x0         <= i_Win_X0;
                r_y0         <= i_Win_Y0;
                r_x_last     <= w_x_lim[POS_W] ? '1 : w_x_lim[POS_W-1:0] - 1'b1;
                r_y_last     <= w_y_lim[POS_W] ? '1 : w_y_lim[POS_W-1:0] - 1'b1;
                o_Overflow   <= 1'b0;
                o_Word_Count <= '0;
            end else begin
                o_Overflow   <= o_Overflow || w_drop;
                o_Word_Count <= (w_accept && o_Word_Count != 16'hFFFF) ? o_Word_Count + 16'd1 : o_Word_Count;
            end
            if (w_take) begin
                r_sr  <= w_sr_next;
                r_cnt <= w_word_done ? '0 : r_cnt + 1'b1;
            end else if (r_state == FLUSH) begin
                r_sr  <= '0;
                r_cnt <= '0;
            end
        end
    end
endmodule

// File: tb/tb_pixel_window_capture.sv
// tb_pixel_window_capture: directed and randomized frames checked against a pixel-list packing model
module tb_pixel_window_capture;
    logic        i_Clk = 1'b0;
    logic        i_Rst_L, i_Arm, i_Continuous, i_Pix_Valid;
    logic [9:0]  i_Win_X0, i_Win_Y0, i_Win_W, i_Win_H, i_Row, i_Column;
    logic [1:0]  i_Pixel;
    logic        o_Busy, o_Frame_Done, o_Overflow;
    logic [15:0] o_Word_Count;
    int          checks = 0, errors = 0, fd_cnt = 0;
    int          mx0, my0, mw, mh;
    bit          rand_ready = 0;
    int          exp_pix[$];
    logic [31:0] exp_words[$], got[$];

    pixel_window_capture_if #(.WORD_BITS(32)) w_if ();

    pixel_window_capture dut (
        .i_Clk(i_Clk), .i_Rst_L(i_Rst_L), .i_Arm(i_Arm), .i_Continuous(i_Continuous),
        .i_Win_X0(i_Win_X0), .i_Win_Y0(i_Win_Y0), .i_Win_W(i_Win_W), .i_Win_H(i_Win_H),
        .i_Pix_Valid(i_Pix_Valid), .i_Row(i_Row), .i_Column(i_Column), .i_Pixel(i_Pixel),
        .o_Words(w_if), .o_Busy(o_Busy), .o_Frame_Done(o_Frame_Done),
        .o_Overflow(o_Overflow), .o_Word_Count(o_Word_Count)
    );

    always #5 i_Clk = ~i_Clk;

    // inputs change 1 time unit after each rising edge, so the falling edge sees settled handshakes
    always @(negedge i_Clk) begin
        if (w_if.word_valid === 1'b1 && w_if.word_ready === 1'b1) got.push_back(w_if.word);
        if (o_Frame_Done === 1'b1) fd_cnt++;
    end

    task automatic tick();
        @(posedge i_Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] gw(input int i);
        return i < got.size() ? got[i] : 32'hDEAD_BEEF;
    endfunction

    function automatic void build_exp();
        logic [31:0] w;
        exp_words.delete();
        for (int i = 0; i < exp_pix.size(); i += 16) begin
            w = '0;
            for (int k = 0; k < 16 && i + k < exp_pix.size(); k++)
                w |= 32'(exp_pix[i + k]) << (30 - 2 * k);
            exp_words.push_back(w);
        end
    endfunction

    task automatic start(input int x0, input int y0, input int w, input int h, input bit cont);
        i_Win_X0 = 10'(x0); i_Win_Y0 = 10'(y0); i_Win_W = 10'(w); i_Win_H = 10'(h);
        i_Continuous = cont; i_Arm = 1'b1;
        tick();
        i_Arm = 1'b0;
        mx0 = x0; my0 = y0; mw = w; mh = h;
        got.delete(); exp_pix.delete(); fd_cnt = 0;
    endtask

    task automatic run_frame(input int ncols, input int nrows, input int pmode, input bit gaps, input int arm_at);
        int p;
        for (int r = 0; r < nrows; r++)
            for (int c = 0; c < ncols; c++) begin
                if (gaps && $urandom_range(0, 3) == 0) begin
                    i_Pix_Valid = 1'b0;
                    tick();
                end
                p = pmode == 0 ? c % 4 : pmode == 1 ? 3 : int'($urandom_range(0, 3));
                i_Pix_Valid = 1'b1; i_Row = 10'(r); i_Column = 10'(c); i_Pixel = 2'(p);
                if (rand_ready) w_if.word_ready = 1'($urandom_range(0, 1));
                if (arm_at == c && r == 0) begin
                    i_Arm = 1'b1; i_Continuous = 1'b0; i_Win_X0 = 10'd2; i_Win_W = 10'd4;
                end
                if (r >= my0 && r < my0 + mh && c >= mx0 && c < mx0 + mw) exp_pix.push_back(p);
                tick();
                i_Arm = 1'b0;
            end
        i_Pix_Valid = 1'b0;
        repeat (4) tick();
    endtask

    task automatic drain(input string tag);
        int n = 0;
        w_if.word_ready = 1'b1;
        while (w_if.word_valid && n < 200) begin
            tick();
            n++;
        end
        chk({tag, "_drained"}, 32'(w_if.word_valid), 0);
    endtask

    task automatic cmp_words(input string tag, input int n);
        chk({tag, "_nwords"}, got.size(), n);
        for (int i = 0; i < n; i++) chk({tag, "_word"}, gw(i), exp_words[i]);
    endtask

    initial begin
        i_Rst_L = 1'b0; i_Arm = 1'b0; i_Continuous = 1'b0; i_Pix_Valid = 1'b0;
        i_Win_X0 = '0; i_Win_Y0 = '0; i_Win_W = '0; i_Win_H = '0;
        i_Row = '0; i_Column = '0; i_Pixel = '0; w_if.word_ready = 1'b1;
        repeat (3) tick();
        chk("por_busy", 32'(o_Busy), 0);
        chk("por_valid", 32'(w_if.word_valid), 0);
        chk("por_ovf", 32'(o_Overflow), 0);
        chk("por_count", 32'(o_Word_Count), 0);
        i_Rst_L = 1'b1;
        tick();

        start(16, 0, 256, 2, 0);
        run_frame(300, 2, 0, 1, -1);
        drain("win");
        build_exp();
        chk("win_first", gw(0), 32'h1B1B1B1B);
        cmp_words("win", 32);
        chk("win_done", fd_cnt, 1);
        chk("win_count", 32'(o_Word_Count), 32);
        chk("win_idle", 32'(o_Busy), 0);

        start(0, 0, 5, 1, 0);
        run_frame(8, 1, 1, 0, -1);
        drain("part");
        chk("part_nwords", got.size(), 1);
        chk("part_word", gw(0), 32'hFFC00000);
        chk("part_done", fd_cnt, 1);

        w_if.word_ready = 1'b0;
        start(0, 0, 80, 2, 0);
        run_frame(100, 2, 2, 1, -1);
        build_exp();
        chk("bp_valid", 32'(w_if.word_valid), 1);
        chk("bp_ovf", 32'(o_Overflow), 1);
        chk("bp_count", 32'(o_Word_Count), 8);
        chk("bp_done", fd_cnt, 1);
        chk("bp_held", gw(0), 32'hDEAD_BEEF);
        drain("bp");
        cmp_words("bp", 8);

        start(1020, 0, 8, 1, 0);
        run_frame(1024, 1, 2, 0, -1);
        drain("edge");
        build_exp();
        cmp_words("edge", 1);
        chk("edge_pad", gw(0) & 32'h00FFFFFF, 0);
        chk("edge_done", fd_cnt, 1);

        for (int t = 0; t < 3; t++) begin
            int x0 = int'($urandom_range(0, 30));
            int y0 = int'($urandom_range(0, 3));
            start(x0, y0, int'($urandom_range(1, 40 - x0)), int'($urandom_range(1, 4 - y0)), 0);
            rand_ready = 1;
            run_frame(40, 4, 2, 1, -1);
            rand_ready = 0;
            drain("rnd");
            build_exp();
            cmp_words("rnd", exp_words.size());
            chk("rnd_count", 32'(o_Word_Count), 32'(exp_words.size()));
            chk("rnd_ovf", 32'(o_Overflow), 0);
            chk("rnd_done", fd_cnt, 1);
        end

        w_if.word_ready = 1'b0;
        start(0, 0, 64, 2, 0);
        for (int c = 0; c < 40; c++) begin
            i_Pix_Valid = 1'b1; i_Row = '0; i_Column = 10'(c); i_Pixel = 2'(c);
            tick();
        end
        i_Pix_Valid = 1'b0;
        chk("mid_busy", 32'(o_Busy), 1);
        chk("mid_valid", 32'(w_if.word_valid), 1);
        i_Rst_L = 1'b0;
        repeat (3) tick();
        chk("rst_busy", 32'(o_Busy), 0);
        chk("rst_valid", 32'(w_if.word_valid), 0);
        chk("rst_ovf", 32'(o_Overflow), 0);
        chk("rst_count", 32'(o_Word_Count), 0);
        i_Rst_L = 1'b1;
        w_if.word_ready = 1'b1;
        tick();

        start(0, 0, 16, 1, 1);
        for (int f = 0; f < 3; f++) begin
            run_frame(20, 1, 2, 1, f == 1 ? 5 : -1);
            chk("cont_busy", 32'(o_Busy), 1);
        end
        build_exp();
        cmp_words("cont", 3);
        chk("cont_done", fd_cnt, 3);
        i_Rst_L = 1'b0;
        repeat (2) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
